// File: rtl/decoder_3x8_fifo.sv
// rtl/decoder_3x8_fifo.sv - buffered 3-to-8 one-hot decoder behind a DEPTH-entry code FIFO
//
// Purpose:
//   Accepts 3-bit binary codes on a valid/ready input handshake and stores them in a
//   DEPTH-entry FIFO. The head entry is presented as a one-hot byte on a valid/ready
//   output handshake. There is no bypass path, so an accepted code becomes visible on
//   out in the cycle after the edge that accepted it.
//
// Parameters:
//   DEPTH      number of buffered codes; 2, 4, 8 or 16 (power of two)
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   in_code    3-bit binary index to decode
//   in_valid   in_code is valid this cycle
//   in_ready   a code can be accepted this cycle (count < DEPTH)
//   out        one-hot decode of the head entry, 8'h00 when empty
//   out_valid  out holds a valid one-hot value (count != 0)
//   out_ready  consumer takes out this cycle
//   count      current occupancy, 0..DEPTH
//   seen       sticky OR of every popped one-hot value   (DECODER_SEEN_EN only)
//   seen_clr   synchronous clear of seen                 (DECODER_SEEN_EN only)
//
// Build option:
//   DECODER_SEEN_EN  when defined, adds the seen/seen_clr ports and their register.

module decoder_3x8_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] count
`ifdef DECODER_SEEN_EN
  ,
  output logic [7:0] seen,
  input  logic       seen_clr
`endif
);

  // Pointer width; DEPTH is a power of two, so AW bits address every entry.
  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]      DEPTH_C  = 5'(DEPTH);
  localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

  // Code storage; contents are meaningless while unoccupied, so it has no reset.
  logic [2:0]      mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [2:0]      head_code;

  // ---------------------------------------------------------------------------
  // Handshake and output decode (registered occupancy only, no input bypass)
  // ---------------------------------------------------------------------------
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != 5'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head_code = mem_q[rd_ptr_q];
  assign out       = out_valid ? (8'd1 << head_code) : 8'h00;
  assign count     = count_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Occupancy FSM: next state and count
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_EMPTY: begin
        // out_ready is irrelevant here: pop is already 0 because out_valid is 0.
        if (push) begin
          count_d = 5'd1;
          state_d = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        // Simultaneous push and pop leave the occupancy untouched.
        if (push && !pop) begin
          count_d = count_q + 5'd1;
          if (count_q == DEPTH_C - 5'd1) state_d = ST_FULL;
        end else if (pop && !push) begin
          count_d = count_q - 5'd1;
          if (count_q == 5'd1) state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low, so only a pop can happen.
        if (pop) begin
          count_d = count_q - 5'd1;
          state_d = ST_PARTIAL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        count_d = 5'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // ---------------------------------------------------------------------------
  // Registers; reset wins over a push/pop in the same cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      count_q  <= 5'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= in_code;
    end
  end

`ifdef DECODER_SEEN_EN
  // ---------------------------------------------------------------------------
  // Sticky record of popped values; a clear coincident with a pop keeps only
  // the value popped in that cycle.
  // ---------------------------------------------------------------------------
  logic [7:0] seen_q, seen_d;

  always_comb begin
    seen_d = seen_q;
    if (pop) begin
      seen_d = seen_clr ? out : (seen_q | out);
    end else if (seen_clr) begin
      seen_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= 8'h00;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign seen = seen_q;
`endif

endmodule

// File: tb/tb_decoder_3x8_fifo.sv
// tb/tb_decoder_3x8_fifo.sv - directed self-checking bench for decoder_3x8_fifo (DEPTH=4)

module tb_decoder_3x8_fifo;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
`ifdef DECODER_SEEN_EN
  logic [7:0] seen;
  logic       seen_clr;
`endif

  int errors;
  int checks;

  decoder_3x8_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef DECODER_SEEN_EN
    ,
    .seen      (seen),
    .seen_clr  (seen_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pushed;
    int popped;
    int cyc;
    logic [2:0] exp_code;
    logic [7:0] exp_out;
    logic [2:0] fill_codes [4];

    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_code   = 3'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef DECODER_SEEN_EN
    seen_clr  = 1'b0;
`endif
    fill_codes[0] = 3'd1;
    fill_codes[1] = 3'd2;
    fill_codes[2] = 3'd3;
    fill_codes[3] = 3'd4;

    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_count",    {3'b0, count}, 8'd0);
    check("rst_outvalid", {7'b0, out_valid}, 8'd0);
    check("rst_out",      out, 8'h00);
    check("rst_inready",  {7'b0, in_ready}, 8'd1);

    // Push 5 then 0 with out_ready low; no bypass before the accepting edge
    in_code  = 3'd5;
    in_valid = 1'b1;
    #1;
    check("nobypass_outvalid", {7'b0, out_valid}, 8'd0);
    tick();
    check("lat1_out", out, 8'h20);
    in_code = 3'd0;
    tick();
    in_valid = 1'b0;
    check("two_out",      out, 8'h20);
    check("two_outvalid", {7'b0, out_valid}, 8'd1);
    check("two_count",    {3'b0, count}, 8'd2);
    out_ready = 1'b1;
    tick();
    check("pop5_out",   out, 8'h01);
    check("pop5_count", {3'b0, count}, 8'd1);
    tick();
    check("pop0_count", {3'b0, count}, 8'd0);
    check("pop0_out",   out, 8'h00);
    tick();
    check("empty_ignore_ready", {3'b0, count}, 8'd0);
    out_ready = 1'b0;

    // Fill to FULL, then a fifth code is dropped
    for (int i = 0; i < 4; i++) begin
      in_code  = fill_codes[i];
      in_valid = 1'b1;
      tick();
    end
    check("full_count",   {3'b0, count}, 8'd4);
    check("full_inready", {7'b0, in_ready}, 8'd0);
    check("full_out",     out, 8'h02);
    in_code = 3'd7;
    tick();
    check("drop5_count", {3'b0, count}, 8'd4);
    check("hold_out",    out, 8'h02);
    check("hold_valid",  {7'b0, out_valid}, 8'd1);

    // FULL with in_valid and out_ready: pop only, then push+pop together
    out_ready = 1'b1;
    tick();
    check("fullpop_count",   {3'b0, count}, 8'd3);
    check("fullpop_out",     out, 8'h04);
    check("fullpop_inready", {7'b0, in_ready}, 8'd1);
    tick();
    check("pushpop_count", {3'b0, count}, 8'd3);
    check("pushpop_out",   out, 8'h08);
    in_valid = 1'b0;
    tick();
    check("drain_a", out, 8'h10);
    tick();
    check("drain_b", out, 8'h80);
    tick();
    check("drain_count", {3'b0, count}, 8'd0);
    out_ready = 1'b0;

    // Stream 0..7,0..3 with random out_ready; order across pointer wrap
    pushed = 0;
    popped = 0;
    cyc    = 0;
    while ((popped < 12) && (cyc < 300)) begin
      in_valid  = (pushed < 12);
      in_code   = 3'(pushed % 8);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        exp_code = 3'(popped % 8);
        exp_out  = 8'd1 << exp_code;
        check("stream_out", out, exp_out);
        popped++;
      end
      if (in_valid && in_ready) pushed++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_popped", 8'(popped), 8'd12);
    check("stream_count",  {3'b0, count}, 8'd0);

    // Reset mid-operation with in_valid high
    for (int i = 0; i < 3; i++) begin
      in_code  = 3'(i + 1);
      in_valid = 1'b1;
      tick();
    end
    check("pre_rst_count", {3'b0, count}, 8'd3);
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("midrst_count",    {3'b0, count}, 8'd0);
    check("midrst_outvalid", {7'b0, out_valid}, 8'd0);
    check("midrst_out",      out, 8'h00);
    check("midrst_inready",  {7'b0, in_ready}, 8'd1);

`ifdef DECODER_SEEN_EN
    check("seen_rst", seen, 8'h00);
    in_valid = 1'b1;
    in_code  = 3'd1;
    tick();
    in_code  = 3'd6;
    tick();
    in_code  = 3'd2;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("seen_or", seen, 8'h42);
    seen_clr = 1'b1;
    tick();
    seen_clr  = 1'b0;
    out_ready = 1'b0;
    check("seen_clr_pop", seen, 8'h04);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_3x8_fifo.md
DECODER_3X8_FIFO -- requirements
Module: decoder_3x8_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered codes; legal values 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_code  input  3  binary index to decode; this is the format produced by the team's 8x3 encoder.
REQ-005 SHALL have port in_valid  input  1  in_code is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept a code this cycle.
REQ-007 SHALL have port out  output  8  one-hot decode of the head entry.
REQ-008 SHALL have port out_valid  output  1  out holds a valid one-hot value.
REQ-009 SHALL have port out_ready  input  1  consumer takes out this cycle.
REQ-010 SHALL have port count  output  5  current occupancy, 0..DEPTH.

Function
REQ-011 SHALL push in_code into a DEPTH-entry FIFO when in_valid && in_ready at a clock edge.
REQ-012 SHALL pop the head entry when out_valid && out_ready at a clock edge.
REQ-013 SHALL drive in_ready = (count < DEPTH), combinationally from registered count only.
REQ-014 SHALL drive out_valid = (count != 0), combinationally from registered count only.
REQ-015 SHALL drive out = 8'b1 << head_code when out_valid, else 8'h00, so exactly one bit is set whenever out_valid is 1.
REQ-016 SHALL have no bypass: a code accepted at edge N appears on out no earlier than the cycle after edge N, giving 1-cycle minimum latency.
REQ-017 SHALL keep state EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH), with transitions driven only by push and pop.
REQ-018 SHALL leave count unchanged on simultaneous push and pop in PARTIAL; both operations take effect.
REQ-019 SHALL perform only the pop in FULL, because in_ready is 0; count decrements to DEPTH-1.
REQ-020 SHALL ignore out_ready in EMPTY; no pop occurs and count stays 0.
REQ-021 SHALL wrap read and write pointers modulo DEPTH, and SHALL preserve FIFO order across the wrap.
REQ-022 SHALL hold out and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL not change state when in_valid is asserted while in_ready is 0; the code is dropped, and the producer is responsible for holding it.

Reset
REQ-024 SHALL, on a rising clk edge with rst_n=0, set count=0, both pointers=0, and state EMPTY, giving out=8'h00, out_valid=0 and in_ready=1 in the following cycle.
REQ-025 SHALL give reset priority over push and pop in the same cycle; buffered entries are discarded mid-operation.
REQ-026 SHALL not require the FIFO storage array to be reset.

Configuration
REQ-027 SHALL, with macro DECODER_SEEN_EN defined, add ports seen (output, 8 bits: sticky OR of every out value popped) and seen_clr (input, 1 bit: synchronous clear).
REQ-028 SHALL reset seen to 8'h00 with rst_n. If seen_clr and a pop occur in the same cycle, seen SHALL be loaded with the popped one-hot value and the older bits cleared.
REQ-029 SHALL, without DECODER_SEEN_EN, omit seen, seen_clr and their logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover: reset, then push codes 3'd5 then 3'd0 with out_ready=0 -> out=8'b0010_0000, out_valid=1, count=2; raise out_ready -> next out=8'b0000_0001.
REQ-031 SHALL cover: DEPTH=4, push 5 codes back-to-back with out_ready=0 -> in_ready=0 after the 4th accept, count=4, and the 5th code is not stored.
REQ-032 SHALL cover: FULL state, in_valid=1, out_ready=1 for one cycle -> only the pop occurs and count=3; next cycle push and pop occur together and count stays 3.
REQ-033 SHALL cover: 12 sequential codes 0..7,0..3 streamed with random out_ready -> outputs appear in order as one-hot 8'h01..8'h80,8'h01..8'h08, exercising pointer wrap.
REQ-034 SHALL cover: count=3, then rst_n=0 for one cycle together with in_valid=1 -> next cycle count=0, out_valid=0, out=8'h00, in_ready=1.
REQ-035 SHALL cover, with DECODER_SEEN_EN defined: pop codes 1 and 6 -> seen=8'b0100_0010; then seen_clr together with a pop of code 2 -> seen=8'b0000_0100.
